// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port pixel SRAM between an SPI write buffer and READ_PORTS round-robin readers.
// Define SRAM_ARBITER_OVERFLOW_EN to enable the sticky overflow flag for dropped strobes.
module sram_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 14,
  parameter int READ_PORTS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ADDRESS_BUS_WIDTH-1:0]           write_address,
  input  logic [15:0]                            write_data,
  input  logic                                   write_strobe,
  input  logic [READ_PORTS*ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic [READ_PORTS-1:0]                  read_strobe,
  output logic [READ_PORTS-1:0]                  read_finished_strobe,
  output logic [15:0]                            read_data,
  output logic [ADDRESS_BUS_WIDTH-1:0]           mem_address,
  output logic [15:0]                            mem_data_in,
  output logic                                   mem_write_en,
  input  logic [15:0]                            mem_data_out,
  output logic                                   overflow,
  input  logic                                   overflow_clear
);
  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int PW = READ_PORTS > 1 ? $clog2(READ_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_e;
  state_e state_q, state_d;
  logic wr_valid_q, wr_valid_d, last_write_q, last_write_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, mem_address_q, mem_address_d;
  logic [15:0] wr_data_q, wr_data_d, mem_data_in_q, mem_data_in_d, read_data_q, read_data_d;
  logic [READ_PORTS-1:0] rd_pend_q, rd_pend_d, rd_clr, read_finished_strobe_q, read_finished_strobe_d;
  logic [READ_PORTS*AW-1:0] rd_addr_q, rd_addr_d;
  logic [PW-1:0] last_grant_q, last_grant_d, rr_port;
  logic [PW:0] rr_sum;
  logic rr_found, grant_wr, grant_rd, mem_write_en_q, mem_write_en_d, overflow_q, overflow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                <= IDLE;
      wr_valid_q             <= 1'b0;
      last_write_q           <= 1'b0;
      wr_addr_q              <= '0;
      wr_data_q              <= '0;
      rd_pend_q              <= '0;
      rd_addr_q              <= '0;
      last_grant_q           <= PW'(READ_PORTS - 1);
      mem_address_q          <= '0;
      mem_data_in_q          <= '0;
      mem_write_en_q         <= 1'b0;
      read_data_q            <= '0;
      read_finished_strobe_q <= '0;
      overflow_q             <= 1'b0;
    end else begin
      state_q                <= state_d;
      wr_valid_q             <= wr_valid_d;
      last_write_q           <= last_write_d;
      wr_addr_q              <= wr_addr_d;
      wr_data_q              <= wr_data_d;
      rd_pend_q              <= rd_pend_d;
      rd_addr_q              <= rd_addr_d;
      last_grant_q           <= last_grant_d;
      mem_address_q          <= mem_address_d;
      mem_data_in_q          <= mem_data_in_d;
      mem_write_en_q         <= mem_write_en_d;
      read_data_q            <= read_data_d;
      read_finished_strobe_q <= read_finished_strobe_d;
      overflow_q             <= overflow_d;
    end
  end

  // Round-robin search begins at the port after the last read grant.
  always_comb begin
    rr_port  = '0;
    rr_found = 1'b0;
    rr_sum   = '0;
    for (int i = 1; i <= READ_PORTS; i++) begin
      rr_sum = {1'b0, last_grant_q} + (PW+1)'(i);
      rr_sum = (rr_sum >= (PW+1)'(READ_PORTS)) ? rr_sum - (PW+1)'(READ_PORTS) : rr_sum;
      if (!rr_found && rd_pend_q[rr_sum[PW-1:0]]) begin
        rr_found = 1'b1;
        rr_port  = rr_sum[PW-1:0];
      end
    end
  end

  // A pending read beats the write buffer only right after a write, so reads cannot starve.
  always_comb begin
    grant_wr = state_q == IDLE && wr_valid_q && !(last_write_q && rr_found);
    grant_rd = state_q == IDLE && rr_found && !grant_wr;
    state_d  = state_q == IDLE ? (grant_wr ? WRITE : grant_rd ? RD_ADDR : IDLE) :
               state_q == RD_ADDR ? RD_DATA : IDLE;
  end

  assign rd_clr = grant_rd ? READ_PORTS'(1) << rr_port : '0;

  always_comb begin
    wr_valid_d   = write_strobe | (wr_valid_q & ~grant_wr);
    wr_addr_d    = write_strobe && (!wr_valid_q || grant_wr) ? write_address : wr_addr_q;
    wr_data_d    = write_strobe && (!wr_valid_q || grant_wr) ? write_data : wr_data_q;
    rd_pend_d    = read_strobe | (rd_pend_q & ~rd_clr);
    rd_addr_d    = rd_addr_q;
    for (int p = 0; p < READ_PORTS; p++)
      if (read_strobe[p] && (!rd_pend_q[p] || rd_clr[p])) rd_addr_d[p*AW +: AW] = read_address[p*AW +: AW];
    last_write_d = grant_wr ? 1'b1 : grant_rd ? 1'b0 : last_write_q;
    last_grant_d = grant_rd ? rr_port : last_grant_q;
  end

  always_comb begin
    mem_address_d          = grant_wr ? wr_addr_q : grant_rd ? rd_addr_q[rr_port*AW +: AW] : mem_address_q;
    mem_data_in_d          = grant_wr ? wr_data_q : mem_data_in_q;
    mem_write_en_d         = grant_wr;
    read_data_d            = state_q == RD_DATA ? mem_data_out : read_data_q;
    read_finished_strobe_d = state_q == RD_DATA ? READ_PORTS'(1) << last_grant_q : '0;
`ifdef SRAM_ARBITER_OVERFLOW_EN
    overflow_d = (write_strobe & wr_valid_q & ~grant_wr) | (|(read_strobe & rd_pend_q & ~rd_clr)) |
                 (overflow_q & ~overflow_clear);
`else
    overflow_d = 1'b0;
`endif
  end

`ifdef SRAM_ARBITER_OVERFLOW_EN
`else
  logic unused_clear;
  assign unused_clear = overflow_clear;
`endif

  assign read_finished_strobe = read_finished_strobe_q;
  assign read_data            = read_data_q;
  assign mem_address          = mem_address_q;
  assign mem_data_in          = mem_data_in_q;
  assign mem_write_en         = mem_write_en_q;
  assign overflow             = overflow_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a registered-read SRAM model.
module tb_sram_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, write_strobe = 1'b0, overflow_clear = 1'b0;
  logic [13:0] write_address = '0, mem_address;
  logic [15:0] write_data = '0, read_data, mem_data_in, mem_data_out;
  logic [55:0] read_address = '0;
  logic [3:0]  read_strobe = '0, read_finished_strobe;
  logic        mem_write_en, overflow;
  int checks = 0, errors = 0;

  sram_arbiter #(.ADDRESS_BUS_WIDTH(14), .READ_PORTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .write_address(write_address), .write_data(write_data),
    .write_strobe(write_strobe), .read_address(read_address), .read_strobe(read_strobe),
    .read_finished_strobe(read_finished_strobe), .read_data(read_data), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .overflow(overflow), .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:16383];
  bit          written [0:16383];

  function automatic logic [15:0] rom(input logic [13:0] a);
    case (a)
      14'h0040: rom = 16'h1234;
      14'h0010: rom = 16'hA000;
      14'h0011: rom = 16'hA111;
      14'h0012: rom = 16'hA222;
      14'h0013: rom = 16'hA333;
      14'h0030: rom = 16'h3030;
      default:  rom = 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_address]     <= mem_data_in;
      written[mem_address] <= 1'b1;
    end
    mem_data_out <= written[mem_address] ? mem[mem_address] : rom(mem_address);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mem_write_en); end
    checks++; if (mem_address !== 14'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_address); end
    checks++; if (mem_data_in !== 16'h0) begin errors++; $display("FAIL rst_din got %h exp 0", mem_data_in); end
    checks++; if (read_data !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", read_data); end
    checks++; if (read_finished_strobe !== 4'h0) begin errors++; $display("FAIL rst_fin got %b exp 0", read_finished_strobe); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write;
    write_address = 14'h0123; write_data = 16'hBEEF; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL wr_t1_we got %b exp 0", mem_write_en); end
    tick();
    checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL wr_t2_we got %b exp 1", mem_write_en); end
    checks++; if (mem_address !== 14'h0123) begin errors++; $display("FAIL wr_t2_addr got %h exp 0123", mem_address); end
    checks++; if (mem_data_in !== 16'hBEEF) begin errors++; $display("FAIL wr_t2_data got %h exp beef", mem_data_in); end
    tick();
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL wr_t3_we got %b exp 0", mem_write_en); end
    checks++; if (mem[14'h0123] !== 16'hBEEF) begin errors++; $display("FAIL wr_stored got %h exp beef", mem[14'h0123]); end
  endtask

  task automatic test_single_read;
    read_address[2*14 +: 14] = 14'h0040; read_strobe = 4'b0100;
    tick();
    read_strobe = '0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        checks++; if (mem_address !== 14'h0040) begin errors++; $display("FAIL rd_addr got %h exp 0040", mem_address); end
      end
      checks++;
      if (read_finished_strobe !== (c == 4 ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL rd_fin c=%0d got %b exp %b", c, read_finished_strobe, c == 4 ? 4'b0100 : 4'b0000);
      end
      if (c >= 4) begin
        checks++; if (read_data !== 16'h1234) begin errors++; $display("FAIL rd_data c=%0d got %h exp 1234", c, read_data); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    read_address[1*14 +: 14] = 14'h0021; read_strobe = 4'b0010;
    tick();
    read_strobe = '0;
    tick();
    tick();
    checks++; if (mem_address !== 14'h0021) begin errors++; $display("FAIL mid_addr got %h exp 0021", mem_address); end
    rst_n = 1'b0;
    #2;
    checks++; if (mem_address !== 14'h0) begin errors++; $display("FAIL mid_rst_addr got %h exp 0", mem_address); end
    checks++; if (mem_data_in !== 16'h0) begin errors++; $display("FAIL mid_rst_din got %h exp 0", mem_data_in); end
    checks++; if (read_data !== 16'h0) begin errors++; $display("FAIL mid_rst_rdata got %h exp 0", read_data); end
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b exp 0", mem_write_en); end
    tick();
    checks++; if (read_finished_strobe !== 4'h0) begin errors++; $display("FAIL mid_rst_fin got %b exp 0", read_finished_strobe); end
    rst_n = 1'b1;
    read_address[0 +: 14] = 14'h0010; read_address[3*14 +: 14] = 14'h0013; read_strobe = 4'b1001;
    tick();
    read_strobe = '0;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (read_finished_strobe !== (c == 4 ? 4'b0001 : c == 7 ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL mid_fin c=%0d got %b", c, read_finished_strobe);
      end
      if (c == 4) begin
        checks++; if (read_data !== 16'hA000) begin errors++; $display("FAIL mid_data0 got %h exp a000", read_data); end
      end
      if (c == 7) begin
        checks++; if (read_data !== 16'hA333) begin errors++; $display("FAIL mid_data3 got %h exp a333", read_data); end
      end
      tick();
    end
  endtask

  task automatic test_all_ports;
    logic [3:0]  exp_s;
    logic [15:0] exp_d;
    for (int p = 0; p < 4; p++) read_address[p*14 +: 14] = 14'h0010 + 14'(p);
    for (int r = 0; r < 2; r++) begin
      read_strobe = 4'b1111;
      tick();
      read_strobe = '0;
      for (int c = 1; c <= 13; c++) begin
        exp_s = c == 4 ? 4'b0001 : c == 7 ? 4'b0010 : c == 10 ? 4'b0100 : c == 13 ? 4'b1000 : 4'b0000;
        exp_d = c == 4 ? 16'hA000 : c == 7 ? 16'hA111 : c == 10 ? 16'hA222 : 16'hA333;
        checks++; if (read_finished_strobe !== exp_s) begin errors++; $display("FAIL all_fin r=%0d c=%0d got %b exp %b", r, c, read_finished_strobe, exp_s); end
        if (exp_s != 4'b0000) begin
          checks++; if (read_data !== exp_d) begin errors++; $display("FAIL all_data r=%0d c=%0d got %h exp %h", r, c, read_data, exp_d); end
        end
        tick();
      end
    end
  endtask

  task automatic test_write_read_mix;
    logic        exp_we;
    logic [13:0] exp_a;
    int          wi;
    read_address[1*14 +: 14] = 14'h0030;
    wi = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        exp_we = c == 2 || c == 7 || c == 9 || c == 11;
        exp_a  = 14'h0200 + 14'(c == 2 ? 0 : c == 7 ? 1 : c == 9 ? 2 : 3);
        checks++; if (mem_write_en !== exp_we) begin errors++; $display("FAIL mix_we c=%0d got %b exp %b", c, mem_write_en, exp_we); end
        if (exp_we) begin
          checks++; if (mem_address !== exp_a) begin errors++; $display("FAIL mix_waddr c=%0d got %h exp %h", c, mem_address, exp_a); end
        end
        if (c == 4) begin
          checks++; if (mem_address !== 14'h0030) begin errors++; $display("FAIL mix_raddr got %h exp 0030", mem_address); end
        end
        checks++;
        if (read_finished_strobe !== (c == 6 ? 4'b0010 : 4'b0000)) begin
          errors++; $display("FAIL mix_fin c=%0d got %b", c, read_finished_strobe);
        end
        if (c == 6) begin
          checks++; if (read_data !== 16'h3030) begin errors++; $display("FAIL mix_rdata got %h exp 3030", read_data); end
        end
      end
      write_strobe = c == 0 || c == 2 || c == 6 || c == 8;
      if (write_strobe) begin
        write_address = 14'h0200 + 14'(wi);
        write_data    = 16'hC000 + 16'(wi);
        wi++;
      end
      read_strobe = c == 1 ? 4'b0010 : 4'b0000;
      tick();
    end
    write_strobe = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mix_ovf got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[14'h0200 + 14'(i)] !== 16'hC000 + 16'(i)) begin
        errors++; $display("FAIL mix_stored i=%0d got %h exp %h", i, mem[14'h0200 + 14'(i)], 16'hC000 + 16'(i));
      end
    end
  endtask

  task automatic test_overflow;
    logic exp_ovf;
    read_address[0 +: 14] = 14'h0040;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
`ifdef SRAM_ARBITER_OVERFLOW_EN
        exp_ovf = c >= 4 && c <= 8;
`else
        exp_ovf = 1'b0;
`endif
        checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf c=%0d got %b exp %b", c, overflow, exp_ovf); end
        checks++; if (mem_write_en !== (c == 5)) begin errors++; $display("FAIL ovf_we c=%0d got %b", c, mem_write_en); end
        if (c == 5) begin
          checks++; if (mem_address !== 14'h0300 || mem_data_in !== 16'hD000) begin
            errors++; $display("FAIL ovf_wr got %h/%h exp 0300/d000", mem_address, mem_data_in);
          end
        end
        if (c == 4) begin
          checks++; if (read_finished_strobe !== 4'b0001 || read_data !== 16'h1234) begin
            errors++; $display("FAIL ovf_rd got %b/%h exp 0001/1234", read_finished_strobe, read_data);
          end
        end
      end
      read_strobe    = c == 0 ? 4'b0001 : 4'b0000;
      write_strobe   = c == 2 || c == 3;
      write_address  = c == 3 ? 14'h0301 : 14'h0300;
      write_data     = c == 3 ? 16'hD001 : 16'hD000;
      overflow_clear = c == 8;
      tick();
    end
    write_strobe = 1'b0; read_strobe = '0; overflow_clear = 1'b0;
    checks++; if (written[14'h0301] !== 1'b0) begin errors++; $display("FAIL ovf_dropped got %b exp 0", written[14'h0301]); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_reset_mid();
    test_all_ports();
    test_write_read_mix();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
